// File: rtl/groovy_cmd_sched.sv
// Command scheduler: grants HPS request flags to the video engines (one at a time)
// and to the audio DMA (independent channel), with per-channel watchdogs.
module groovy_cmd_sched #(
    parameter int unsigned TIMEOUT_W = 24
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cmd_init,
    input  logic        cmd_switchres,
    output logic        reset_switchres,
    input  logic        cmd_blit,
    output logic        reset_blit,
    input  logic        cmd_blit_lz4,
    input  logic        lz4_AB,
    input  logic [31:0] lz4_size,
    output logic        reset_blit_lz4,
    input  logic        cmd_audio,
    input  logic [15:0] audio_samples,
    output logic        reset_audio,
    input  logic        vga_vblank,
    output logic        modeline_start,
    output logic        blit_start,
    output logic        lz4_start,
    input  logic        modeline_done,
    input  logic        blit_done,
    input  logic        lz4_done,
    output logic [31:0] lz4_len,
    output logic        lz4_buf,
    output logic        audio_start,
    output logic [15:0] audio_len,
    input  logic        audio_done,
    output logic        video_abort,
    output logic        audio_abort,
    output logic        video_busy,
    output logic        audio_busy,
    output logic [1:0]  timeout_err
);

    // Counter value at which the next increment would reach all-ones.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        V_IDLE     = 3'd0,
        V_SWR_WAIT = 3'd1,
        V_SWR      = 3'd2,
        V_BLIT     = 3'd3,
        V_LZ4      = 3'd4
    } v_state_e;

    typedef enum logic {
        A_IDLE = 1'b0,
        A_RUN  = 1'b1
    } a_state_e;

    v_state_e             v_state, v_next;
    a_state_e             a_state, a_next;
    logic [TIMEOUT_W-1:0] v_cnt, a_cnt;

    logic req_swr_c, req_lz4_c, req_blit_c, req_aud_c;
    logic v_run_c, v_done_c, v_to_c, a_done_c, a_to_c;
    logic swr_go_c, lz4_go_c, blit_go_c, aud_go_c;

    // The registered ack doubles as the one-cycle mask while the upstream flag falls.
    assign req_swr_c  = cmd_switchres & ~reset_switchres;
    assign req_lz4_c  = cmd_blit_lz4  & ~reset_blit_lz4;
    assign req_blit_c = cmd_blit      & ~reset_blit;
    assign req_aud_c  = cmd_audio     & ~reset_audio;

    assign v_run_c  = (v_state == V_SWR) || (v_state == V_BLIT) || (v_state == V_LZ4);
    assign v_done_c = ((v_state == V_SWR)  && modeline_done) ||
                      ((v_state == V_BLIT) && blit_done)     ||
                      ((v_state == V_LZ4)  && lz4_done);
    assign v_to_c   = v_run_c && !v_done_c && (v_cnt == CNT_LAST);
    assign a_done_c = (a_state == A_RUN) && audio_done;
    assign a_to_c   = (a_state == A_RUN) && !audio_done && (a_cnt == CNT_LAST);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            v_state <= V_IDLE;
            a_state <= A_IDLE;
        end else begin
            v_state <= v_next;
            a_state <= a_next;
        end
    end

    always_comb begin
        v_next = v_state;
        a_next = a_state;
        case (v_state)
            V_IDLE: begin
                if (cmd_init) begin
                    if (req_swr_c)       v_next = V_SWR_WAIT;
                    else if (req_lz4_c)  v_next = V_LZ4;
                    else if (req_blit_c) v_next = V_BLIT;
                end
            end
            V_SWR_WAIT: begin
                if (!cmd_init)       v_next = V_IDLE;
                else if (vga_vblank) v_next = V_SWR;
            end
            V_SWR, V_BLIT, V_LZ4: begin
                if (v_done_c || v_to_c) v_next = V_IDLE;
            end
            default: v_next = V_IDLE;
        endcase
        case (a_state)
            A_IDLE:  if (cmd_init && req_aud_c) a_next = A_RUN;
            A_RUN:   if (a_done_c || a_to_c)    a_next = A_IDLE;
            default: a_next = A_IDLE;
        endcase
    end

    // Grant decode; switchres outranks lz4, which outranks raw blit.
    always_comb begin
        swr_go_c  = 1'b0;
        lz4_go_c  = 1'b0;
        blit_go_c = 1'b0;
        aud_go_c  = 1'b0;
        if (v_state == V_SWR_WAIT) begin
            swr_go_c = cmd_init && vga_vblank;
        end
        if ((v_state == V_IDLE) && cmd_init && !req_swr_c) begin
            lz4_go_c  = req_lz4_c;
            blit_go_c = !req_lz4_c && req_blit_c;
        end
        if (a_state == A_IDLE) begin
            aud_go_c = cmd_init && req_aud_c;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            reset_switchres <= 1'b0;
            reset_blit      <= 1'b0;
            reset_blit_lz4  <= 1'b0;
            reset_audio     <= 1'b0;
            modeline_start  <= 1'b0;
            blit_start      <= 1'b0;
            lz4_start       <= 1'b0;
            audio_start     <= 1'b0;
            video_abort     <= 1'b0;
            audio_abort     <= 1'b0;
            video_busy      <= 1'b0;
            audio_busy      <= 1'b0;
            lz4_len         <= '0;
            lz4_buf         <= 1'b0;
            audio_len       <= '0;
            timeout_err     <= '0;
            v_cnt           <= '0;
            a_cnt           <= '0;
        end else begin
            reset_switchres <= swr_go_c;
            modeline_start  <= swr_go_c;
            reset_blit_lz4  <= lz4_go_c;
            lz4_start       <= lz4_go_c;
            reset_blit      <= blit_go_c;
            blit_start      <= blit_go_c;
            reset_audio     <= aud_go_c;
            audio_start     <= aud_go_c;
            video_abort     <= v_to_c;
            audio_abort     <= a_to_c;
            video_busy      <= (v_next != V_IDLE);
            audio_busy      <= (a_next == A_RUN);
            v_cnt           <= v_run_c ? v_cnt + TIMEOUT_W'(1) : '0;
            a_cnt           <= (a_state == A_RUN) ? a_cnt + TIMEOUT_W'(1) : '0;
            if (lz4_go_c) begin
                lz4_len <= lz4_size;
                lz4_buf <= lz4_AB;
            end
            if (aud_go_c) begin
                audio_len <= audio_samples;
            end
            if (!cmd_init) timeout_err <= '0;
            else           timeout_err <= timeout_err | {a_to_c, v_to_c};
        end
    end

endmodule

// File: tb/tb_groovy_cmd_sched.sv
// Bench for groovy_cmd_sched: directed scenarios plus a random run checked
// against a job-level reference model.
module tb_groovy_cmd_sched;

    localparam int unsigned TW        = 4;
    localparam int          AGE_LIMIT = (1 << TW) - 2;
    localparam int          J_NONE = 0, J_WAIT = 1, J_SWR = 2, J_BLIT = 3, J_LZ4 = 4;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        cmd_init, cmd_switchres, cmd_blit, cmd_blit_lz4, lz4_AB, cmd_audio;
    logic [31:0] lz4_size;
    logic [15:0] audio_samples;
    logic        vga_vblank, modeline_done, blit_done, lz4_done, audio_done;
    logic        reset_switchres, reset_blit, reset_blit_lz4, reset_audio;
    logic        modeline_start, blit_start, lz4_start, audio_start;
    logic [31:0] lz4_len;
    logic        lz4_buf;
    logic [15:0] audio_len;
    logic        video_abort, audio_abort, video_busy, audio_busy;
    logic [1:0]  timeout_err;

    int n_checks = 0;
    int n_err    = 0;

    bit auto_drop = 1'b1;
    bit drop_swr, drop_blit, drop_lz4, drop_aud;

    // Reference model state
    int          vjob, vage, ajob, aage;
    bit          m_rst_swr, m_rst_blit, m_rst_lz4, m_rst_aud;
    bit          m_ml_start, m_blit_start, m_lz4_start, m_aud_start;
    bit          m_vabort, m_aabort, m_vbusy, m_abusy;
    bit [1:0]    m_err;
    bit [31:0]   m_lz4_len;
    bit          m_lz4_buf;
    bit [15:0]   m_aud_len;

    groovy_cmd_sched #(.TIMEOUT_W(TW)) dut (
        .clk_sys(clk_sys), .reset(reset), .cmd_init(cmd_init),
        .cmd_switchres(cmd_switchres), .reset_switchres(reset_switchres),
        .cmd_blit(cmd_blit), .reset_blit(reset_blit),
        .cmd_blit_lz4(cmd_blit_lz4), .lz4_AB(lz4_AB), .lz4_size(lz4_size),
        .reset_blit_lz4(reset_blit_lz4),
        .cmd_audio(cmd_audio), .audio_samples(audio_samples), .reset_audio(reset_audio),
        .vga_vblank(vga_vblank),
        .modeline_start(modeline_start), .blit_start(blit_start), .lz4_start(lz4_start),
        .modeline_done(modeline_done), .blit_done(blit_done), .lz4_done(lz4_done),
        .lz4_len(lz4_len), .lz4_buf(lz4_buf),
        .audio_start(audio_start), .audio_len(audio_len), .audio_done(audio_done),
        .video_abort(video_abort), .audio_abort(audio_abort),
        .video_busy(video_busy), .audio_busy(audio_busy), .timeout_err(timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [62:0] outs();
        return {reset_switchres, reset_blit, reset_blit_lz4, reset_audio,
                modeline_start, blit_start, lz4_start, audio_start,
                video_abort, audio_abort, video_busy, audio_busy,
                timeout_err, lz4_buf, lz4_len, audio_len};
    endfunction

    function automatic logic [62:0] m_outs();
        return {m_rst_swr, m_rst_blit, m_rst_lz4, m_rst_aud,
                m_ml_start, m_blit_start, m_lz4_start, m_aud_start,
                m_vabort, m_aabort, m_vbusy, m_abusy,
                m_err, m_lz4_buf, m_lz4_len, m_aud_len};
    endfunction

    // One clock of the job-level model, using the inputs about to be sampled.
    task automatic model_step();
        bit p_swr, p_lz4, p_blit, p_aud, v_to, a_to, fin;
        p_swr  = cmd_switchres && !m_rst_swr;
        p_lz4  = cmd_blit_lz4  && !m_rst_lz4;
        p_blit = cmd_blit      && !m_rst_blit;
        p_aud  = cmd_audio     && !m_rst_aud;
        {m_rst_swr, m_rst_blit, m_rst_lz4, m_rst_aud} = '0;
        {m_ml_start, m_blit_start, m_lz4_start, m_aud_start, m_vabort, m_aabort} = '0;
        v_to = 1'b0;
        a_to = 1'b0;
        if (reset) begin
            vjob = J_NONE; ajob = J_NONE; vage = 0; aage = 0;
            m_err = '0; m_lz4_len = '0; m_lz4_buf = 1'b0; m_aud_len = '0;
            m_vbusy = 1'b0; m_abusy = 1'b0;
            return;
        end
        case (vjob)
            J_NONE: if (cmd_init) begin
                if (p_swr) vjob = J_WAIT;
                else if (p_lz4) begin
                    m_lz4_start = 1'b1; m_rst_lz4 = 1'b1;
                    m_lz4_len = lz4_size; m_lz4_buf = lz4_AB;
                    vjob = J_LZ4; vage = 0;
                end else if (p_blit) begin
                    m_blit_start = 1'b1; m_rst_blit = 1'b1;
                    vjob = J_BLIT; vage = 0;
                end
            end
            J_WAIT: if (!cmd_init) vjob = J_NONE;
                    else if (vga_vblank) begin
                        m_ml_start = 1'b1; m_rst_swr = 1'b1;
                        vjob = J_SWR; vage = 0;
                    end
            default: begin
                fin = (vjob == J_SWR && modeline_done) || (vjob == J_BLIT && blit_done) ||
                      (vjob == J_LZ4 && lz4_done);
                if (fin) vjob = J_NONE;
                else if (vage == AGE_LIMIT) begin
                    m_vabort = 1'b1; v_to = 1'b1; vjob = J_NONE;
                end else vage++;
            end
        endcase
        if (ajob == J_NONE) begin
            if (cmd_init && p_aud) begin
                m_aud_start = 1'b1; m_rst_aud = 1'b1; m_aud_len = audio_samples;
                ajob = 1; aage = 0;
            end
        end else if (audio_done) ajob = J_NONE;
        else if (aage == AGE_LIMIT) begin
            m_aabort = 1'b1; a_to = 1'b1; ajob = J_NONE;
        end else aage++;
        m_vbusy = (vjob != J_NONE);
        m_abusy = (ajob != J_NONE);
        m_err   = cmd_init ? (m_err | {a_to, v_to}) : 2'b00;
    endtask

    // Advance one clock; upstream flags fall one cycle after their ack is seen.
    task automatic tick();
        model_step();
        @(posedge clk_sys);
        #1;
        if (auto_drop) begin
            if (drop_swr)  cmd_switchres = 1'b0;
            if (drop_blit) cmd_blit      = 1'b0;
            if (drop_lz4)  cmd_blit_lz4  = 1'b0;
            if (drop_aud)  cmd_audio     = 1'b0;
        end
        drop_swr  = reset_switchres;
        drop_blit = reset_blit;
        drop_lz4  = reset_blit_lz4;
        drop_aud  = reset_audio;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_checks++;
        if (outs() !== 63'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h exp 0", outs());
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (outs() !== 63'd0) begin
            n_err++; $display("FAIL idle_outputs: got %h exp 0", outs());
        end
    endtask

    task automatic test_priority();
        int starts = 0;
        vga_vblank = 1'b0; lz4_AB = 1'b1; lz4_size = 32'h1234;
        cmd_blit = 1'b1; cmd_blit_lz4 = 1'b1; cmd_switchres = 1'b1;
        repeat (6) begin
            tick();
            starts += int'(modeline_start) + int'(blit_start) + int'(lz4_start);
        end
        n_checks++;
        if (starts !== 0 || video_busy !== 1'b1) begin
            n_err++; $display("FAIL prio_wait_vblank: starts %0d busy %b exp 0/1", starts, video_busy);
        end
        vga_vblank = 1'b1;
        tick();
        vga_vblank = 1'b0;
        n_checks++;
        if ({modeline_start, reset_switchres, lz4_start, blit_start} !== 4'b1100) begin
            n_err++; $display("FAIL prio_modeline: got %b exp 1100",
                              {modeline_start, reset_switchres, lz4_start, blit_start});
        end
        repeat (3) tick();
        modeline_done = 1'b1;
        tick();
        modeline_done = 1'b0;
        n_checks++;
        if ({video_busy, lz4_start} !== 2'b00) begin
            n_err++; $display("FAIL prio_idle_gap: got %b exp 00", {video_busy, lz4_start});
        end
        tick();
        n_checks++;
        if ({lz4_start, reset_blit_lz4, blit_start} !== 3'b110 || lz4_len !== 32'h1234 ||
            lz4_buf !== 1'b1) begin
            n_err++; $display("FAIL prio_lz4: got %b len %h buf %b exp 110 1234 1",
                              {lz4_start, reset_blit_lz4, blit_start}, lz4_len, lz4_buf);
        end
        repeat (2) tick();
        lz4_done = 1'b1;
        tick();
        lz4_done = 1'b0;
        tick();
        n_checks++;
        if ({blit_start, reset_blit} !== 2'b11) begin
            n_err++; $display("FAIL prio_blit_last: got %b exp 11", {blit_start, reset_blit});
        end
        tick();
        blit_done = 1'b1;
        tick();
        blit_done = 1'b0;
        tick();
    endtask

    task automatic test_single_grant();
        int extra = 0;
        bit busy_ok = 1'b1;
        cmd_blit = 1'b1;
        tick();
        n_checks++;
        if ({blit_start, reset_blit} !== 2'b11) begin
            n_err++; $display("FAIL single_grant: got %b exp 11", {blit_start, reset_blit});
        end
        repeat (6) begin
            tick();
            extra += int'(blit_start) + int'(reset_blit);
            if (video_busy !== 1'b1) busy_ok = 1'b0;
        end
        n_checks++;
        if (extra !== 0 || !busy_ok) begin
            n_err++; $display("FAIL single_no_regrant: extra %0d busy_ok %b exp 0 1", extra, busy_ok);
        end
        blit_done = 1'b1;
        tick();
        blit_done = 1'b0;
        n_checks++;
        if (video_busy !== 1'b0) begin
            n_err++; $display("FAIL single_done_idle: busy %b exp 0", video_busy);
        end
    endtask

    task automatic test_parallel();
        cmd_audio = 1'b1; audio_samples = 16'h0200; cmd_blit = 1'b1;
        tick();
        n_checks++;
        if ({audio_start, blit_start, reset_audio, reset_blit} !== 4'hF || audio_len !== 16'h0200 ||
            {video_busy, audio_busy} !== 2'b11) begin
            n_err++; $display("FAIL parallel_grant: got %b len %h busy %b exp 1111 0200 11",
                              {audio_start, blit_start, reset_audio, reset_blit}, audio_len,
                              {video_busy, audio_busy});
        end
        tick();
        audio_done = 1'b1; blit_done = 1'b1;
        tick();
        audio_done = 1'b0; blit_done = 1'b0;
        n_checks++;
        if ({video_busy, audio_busy} !== 2'b00) begin
            n_err++; $display("FAIL parallel_done: busy %b exp 00", {video_busy, audio_busy});
        end
    endtask

    task automatic test_watchdog();
        int early = 0;
        cmd_blit = 1'b1;
        tick();
        for (int k = 1; k <= 14; k++) begin
            tick();
            early += int'(video_abort);
        end
        tick();
        n_checks++;
        if (early !== 0 || video_abort !== 1'b1 || timeout_err !== 2'b01 || video_busy !== 1'b0) begin
            n_err++; $display("FAIL wd_abort: early %0d abort %b err %b busy %b exp 0 1 01 0",
                              early, video_abort, timeout_err, video_busy);
        end
        tick();
        n_checks++;
        if (video_abort !== 1'b0 || timeout_err !== 2'b01) begin
            n_err++; $display("FAIL wd_sticky: abort %b err %b exp 0 01", video_abort, timeout_err);
        end
        cmd_init = 1'b0;
        tick();
        cmd_init = 1'b1;
        n_checks++;
        if (timeout_err !== 2'b00) begin
            n_err++; $display("FAIL wd_err_clear: err %b exp 00", timeout_err);
        end
        cmd_blit = 1'b1;
        tick();
        repeat (14) tick();
        blit_done = 1'b1;
        tick();
        blit_done = 1'b0;
        n_checks++;
        if ({video_abort, timeout_err, video_busy} !== 4'b0000) begin
            n_err++; $display("FAIL wd_done_wins: got %b exp 0000", {video_abort, timeout_err, video_busy});
        end
    endtask

    task automatic test_init_gating();
        int seen = 0;
        cmd_init = 1'b0; vga_vblank = 1'b1; cmd_switchres = 1'b1;
        repeat (5) begin
            tick();
            seen += int'(modeline_start) + int'(reset_switchres) + int'(video_busy);
        end
        n_checks++;
        if (seen !== 0) begin
            n_err++; $display("FAIL gate_no_grant: activity %0d exp 0", seen);
        end
        cmd_init = 1'b1; vga_vblank = 1'b0;
        tick();
        cmd_init = 1'b0;
        tick();
        n_checks++;
        if ({video_busy, reset_switchres, modeline_start} !== 3'b000) begin
            n_err++; $display("FAIL gate_wait_cancel: got %b exp 000",
                              {video_busy, reset_switchres, modeline_start});
        end
        cmd_init = 1'b1;
        tick();
        vga_vblank = 1'b1;
        tick();
        vga_vblank = 1'b0;
        n_checks++;
        if ({modeline_start, reset_switchres} !== 2'b11) begin
            n_err++; $display("FAIL gate_grant_vblank: got %b exp 11", {modeline_start, reset_switchres});
        end
        tick();
        modeline_done = 1'b1;
        tick();
        modeline_done = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_job();
        logic [31:0] sz;
        sz = $urandom;
        auto_drop = 1'b0;
        cmd_blit_lz4 = 1'b1; lz4_size = sz; lz4_AB = 1'b1;
        tick();
        repeat (3) tick();
        n_checks++;
        if (video_busy !== 1'b1) begin
            n_err++; $display("FAIL rst_job_running: busy %b exp 1", video_busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (outs() !== 63'd0) begin
            n_err++; $display("FAIL rst_all_zero: got %h exp 0", outs());
        end
        tick();
        n_checks++;
        if ({lz4_start, reset_blit_lz4} !== 2'b11 || lz4_len !== sz) begin
            n_err++; $display("FAIL rst_regrant: got %b len %h exp 11 %h",
                              {lz4_start, reset_blit_lz4}, lz4_len, sz);
        end
        cmd_blit_lz4 = 1'b0;
        auto_drop = 1'b1;
        tick();
        lz4_done = 1'b1;
        tick();
        lz4_done = 1'b0;
        tick();
    endtask

    task automatic test_random();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            cmd_init   = ($urandom_range(0, 31) != 0);
            vga_vblank = ($urandom_range(0, 3) == 0);
            if (!cmd_switchres && $urandom_range(0, 7) == 0) cmd_switchres = 1'b1;
            if (!cmd_blit && $urandom_range(0, 5) == 0) cmd_blit = 1'b1;
            if (!cmd_blit_lz4 && $urandom_range(0, 5) == 0) begin
                cmd_blit_lz4 = 1'b1; lz4_size = $urandom; lz4_AB = 1'($urandom_range(0, 1));
            end
            if (!cmd_audio && $urandom_range(0, 4) == 0) begin
                cmd_audio = 1'b1; audio_samples = 16'($urandom);
            end
            modeline_done = ($urandom_range(0, 5) == 0);
            blit_done     = ($urandom_range(0, 5) == 0);
            lz4_done      = ($urandom_range(0, 5) == 0);
            audio_done    = ($urandom_range(0, 5) == 0);
            reset         = ($urandom_range(0, 299) == 0);
            tick();
            n_checks++;
            if (outs() !== m_outs()) begin
                n_err++; $display("FAIL random_cycle %0d: dut %h model %h", c, outs(), m_outs());
            end
        end
        reset = 1'b0;
        {modeline_done, blit_done, lz4_done, audio_done} = '0;
    endtask

    initial begin
        reset = 1'b1; cmd_init = 1'b1;
        cmd_switchres = 1'b0; cmd_blit = 1'b0; cmd_blit_lz4 = 1'b0; cmd_audio = 1'b0;
        lz4_AB = 1'b0; lz4_size = '0; audio_samples = '0; vga_vblank = 1'b0;
        modeline_done = 1'b0; blit_done = 1'b0; lz4_done = 1'b0; audio_done = 1'b0;
        drop_swr = 1'b0; drop_blit = 1'b0; drop_lz4 = 1'b0; drop_aud = 1'b0;
        vjob = J_NONE; ajob = J_NONE; vage = 0; aage = 0;
        test_reset();
        test_priority();
        test_single_grant();
        test_parallel();
        test_watchdog();
        test_init_gating();
        test_reset_mid_job();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/groovy_cmd_sched.md
# groovy_cmd_sched

Command scheduler between the HPS command decoder and the Groovy video/audio engines. It takes the level-style request flags raised by HPS writes (switchres, raw blit, LZ4 blit, audio), grants them to the modeline loader, raw-blit DMA, LZ4 decompressor and audio DMA, and returns the one-cycle `reset_*` acknowledge that clears each flag. The video engines share the DDR read port, so at most one video job runs at a time. Audio is scheduled on an independent channel. A per-channel watchdog recovers from engines that never report done.

## Interface
Parameters:
- TIMEOUT_W, 24: watchdog counter width. Timeout fires when the counter reaches all-ones.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_init  in  1  session active; while low, no new grants are issued
- cmd_switchres  in  1  switchres request flag (level)
- reset_switchres  out  1  switchres acknowledge pulse
- cmd_blit  in  1  raw blit request flag
- reset_blit  out  1  raw blit acknowledge pulse
- cmd_blit_lz4  in  1  LZ4 blit request flag
- lz4_AB  in  1  LZ4 source buffer select (0=A, 1=B)
- lz4_size  in  32  compressed byte count
- reset_blit_lz4  out  1  LZ4 acknowledge pulse
- cmd_audio  in  1  audio request flag
- audio_samples  in  16  sample count
- reset_audio  out  1  audio acknowledge pulse
- vga_vblank  in  1  vertical blank from the video timing generator
- modeline_start, blit_start, lz4_start  out  1 each  one-cycle engine start pulses
- modeline_done, blit_done, lz4_done  in  1 each  one-cycle engine completion pulses
- lz4_len  out  32  LZ4 length latched at grant
- lz4_buf  out  1  LZ4 buffer latched at grant
- audio_start  out  1  audio start pulse
- audio_len  out  16  audio length latched at grant
- audio_done  in  1  audio completion pulse
- video_abort, audio_abort  out  1 each  one-cycle abort pulses to the engine on timeout
- video_busy, audio_busy  out  1 each  channel is not IDLE
- timeout_err  out  2  sticky watchdog flags: [0] video, [1] audio

## Operation
- Video FSM states: V_IDLE, V_SWR_WAIT, V_SWR, V_BLIT, V_LZ4.
  - V_IDLE with cmd_init=1 grants by fixed priority: switchres > lz4 > blit.
  - Switchres goes V_IDLE → V_SWR_WAIT. It waits for vga_vblank=1, then issues modeline_start and reset_switchres in the same cycle and enters V_SWR.
  - lz4 and blit grant directly from V_IDLE: the `*_start` and `reset_*` pulses fire, and the state moves to V_LZ4 or V_BLIT.
  - lz4_len and lz4_buf latch at grant and hold until the next LZ4 grant.
- Audio FSM states: A_IDLE, A_RUN.
  - A_IDLE with cmd_audio=1 and cmd_init=1: audio_start, reset_audio and the audio_len latch all occur, then the FSM enters A_RUN.
  - audio_done returns the FSM to A_IDLE.
- Acknowledge masking:
  - The upstream flag drops one cycle after `reset_*` is seen, so the sampled request is still high in the cycle after the ack.
  - Each request bit is therefore masked for exactly one cycle after its ack. A new request can never be granted twice.
- Job completion: the matching done pulse returns the FSM to IDLE. Done pulses from non-active engines are ignored.
- Watchdog: each channel counter clears at grant and increments every cycle in a run state (V_SWR_WAIT excluded).
  - At all-ones: pulse `*_abort`, set the matching timeout_err bit, return to IDLE.
  - Done and timeout in the same cycle: done wins, no error.
- timeout_err clears only on reset or while cmd_init=0.
- cmd_init low:
  - V_SWR_WAIT returns to V_IDLE without acknowledging; the flag stays pending.
  - Running jobs complete normally.
- Reset: both FSMs go IDLE; every output and counter is 0; the masks are cleared.

## Timing
- Grant latency is 1 cycle: a request high at edge N in IDLE gives the start and ack pulses during cycle N+1.
- Switchres latency is 1 cycle from the first vblank-high sample in V_SWR_WAIT.
- Done at edge N gives IDLE in cycle N+1. The earliest next grant is in cycle N+2.
- All outputs are registered; pulses are exactly 1 cycle wide.
- Simultaneous requests: one grant per cycle per channel. The others stay pending and are served in priority order.
- Video and audio can grant in the same cycle.

## Test plan
- Video priority:
  - Stimulus: cmd_blit, cmd_blit_lz4 (lz4_AB=1, lz4_size=0x1234) and cmd_switchres raised together, vga_vblank=0.
  - Response: no grant until vblank. Then modeline_start. After modeline_done, lz4_start with lz4_len=0x1234 and lz4_buf=1. After lz4_done, blit_start.
- Single grant per request:
  - Stimulus: a cmd_blit level that drops one cycle after reset_blit.
  - Response: exactly one blit_start and one reset_blit, and video_busy=1 until blit_done.
- Parallel channels:
  - Stimulus: cmd_audio (audio_samples=0x0200) in the same cycle as cmd_blit.
  - Response: audio_start and blit_start in the same cycle, audio_len=0x0200.
- Watchdog:
  - Stimulus: TIMEOUT_W=4, blit granted and blit_done never asserted.
  - Response: video_abort on cycle 15 after grant, timeout_err=2'b01, V_IDLE. With blit_done on that same cycle: no abort and timeout_err=0.
- cmd_init gating:
  - Stimulus: cmd_init=0 with cmd_switchres pending.
  - Response: no grant and no ack. Raising cmd_init gives a grant at the next vblank.
- Reset mid-job:
  - Stimulus: reset during V_LZ4.
  - Response: next cycle all outputs are 0 and both busy flags are low. The still-high cmd_blit_lz4 is re-granted 1 cycle after reset deasserts.
